periph_seg7_mux: RTL and testbench
==================================

Name: periph_seg7_mux

Overview:
- Parametrised multiplexed 7-segment display controller on the peripheral register bus; successor of the fixed 4-digit LED driver.
- Drives DIGITS common-select lines and 8 segment lines (DP,G..A) with a programmable scan prescaler, an anti-ghosting blank interval, full hex decode (0-F), raw-segment mode and per-digit DP/blank.
- Board pin ordering is handled in the top level, not here.

Parameters:
- DATA_WIDTH, 32: bus data width; must be at least 20.
- ADDR_WIDTH, 4: bus address width; 2**ADDR_WIDTH must be at least DIGITS+4.
- DIGITS, 4: number of digits, 1..8.
- PRESCALE, 1000: clocks per digit slot, at least 2.
- BLANK, 16: leading clocks of each slot with all digits off; must be less than PRESCALE.
- SEG_ACTIVE_LOW, 1: 1 means a lit segment is driven 0.
- DIG_ACTIVE_LOW, 1: 1 means a selected digit is driven 0.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous reset, active-high.
- addr  in  ADDR_WIDTH  register address.
- data  inout  DATA_WIDTH  bidirectional bus data.
- read  in  1  read strobe.
- write  in  1  write strobe.
- ready  out  1  transfer acknowledge.
- seg  out  8  {DP,G,F,E,D,C,B,A}, polarity per SEG_ACTIVE_LOW.
- dig  out  DIGITS  digit selects, bit i = digit i, polarity per DIG_ACTIVE_LOW.

Behaviour:
- Register map:
  - 0 = device class, RO, constant 32'h0000_7E60.
  - 1 = vid/pid, RO, constant 32'h0001_0002.
  - 2 = CFG, RW: [7:0] digit enable mask (bits at or above DIGITS read 0); [8] RAW mode; [9] global EN; [19:16] brightness.
  - 3 = STATUS, RO: [2:0] current scan index; [8] frame toggle.
  - 4..4+DIGITS-1 = DIGn, RW: hex mode uses [3:0] value, [4] DP, [5] blank; RAW mode uses [7:0] segments, 1 = lit.
  - Unmapped addresses read 0; writes to them are ignored.
- Bus:
  - ready = read | write, combinational.
  - Write: captured at posedge clk when write=1. Only implemented bits are stored; all others read 0.
  - Read: data is driven combinationally with the addressed register while read=1 and write=0; otherwise data is Z.
  - read and write high together: the write is performed and data stays Z.
  - Writes to RO registers are ignored.
- Scan:
  - slot_cnt counts 0..PRESCALE-1.
  - At the terminal count, slot_cnt returns to 0 and idx advances; idx wraps DIGITS-1 -> 0.
  - Frame toggle flips on every idx wrap.
- Drive, registered with one-cycle latency. dig bit idx is active only when all of these hold:
  - EN=1
  - CFG[idx]=1
  - slot_cnt >= BLANK
  - DIGidx[5]=0 in hex mode (no blank condition in RAW mode)
- All other dig bits are inactive.
- seg carries the pattern for DIGidx whenever dig is active, and is all-off otherwise.
- Hex decode uses standard patterns, logical {DP,G..A}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07
  - 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71
  - Bit 7 = DIG[4].
- A register write becomes visible on the outputs at most 1 clock after the write edge, or at the next slot if the digit is not currently selected.
- Reset, mid-operation included: slot_cnt=0, idx=0, toggle=0, CFG=0, all DIGn=0.
  - seg and dig go to their inactive levels on the next clock.
  - A write in the same cycle as rst is discarded.

Optional Feature:
- Macro SEG7_PWM_EN.
- Defined:
  - A 4-bit pwm_cnt increments every clock and resets to 0.
  - dig additionally requires pwm_cnt <= CFG[19:16]. Brightness 15 = full on; 0 = 1/16 duty.
- Undefined:
  - CFG[19:16] is not stored, reads 0 and has no effect; duty is always full.

Test Plan (DIGITS=4, PRESCALE=8, BLANK=2, both polarities active-low):
- Reset, then observe 40 clocks -> seg=8'hFF and dig=4'hF throughout; STATUS reads 0.
- Write DIG0=3, DIG1=5'h1A (A + DP), CFG=0x20F -> slot 0 seg=~8'h4F and dig=4'b1110 for clocks 2..7 of the slot; slot 1 seg=~8'hF7 and dig=4'b1101; dig=4'hF during clocks 0..1 of each slot.
- Set DIG2[5]=1, or clear CFG bit 2 -> dig[2] never active; other digits unaffected. STATUS[8] toggles every 32 clocks.
- Set CFG=0x30F with DIG3=8'h81 -> in slot 3, seg=~8'h81.
- Read addr 1 -> data=32'h0001_0002 and ready=1. Read addr 15 -> 0. Read and write together -> data is Z and the write lands. Write addr 0 -> value unchanged.
- With SEG7_PWM_EN defined and brightness 3 -> dig active 4 of every 16 clocks in the unblanked slot window. Assert rst mid-slot -> all outputs inactive next clock, idx=0.

Source files
------------

// File: rtl/periph_seg7_mux_if.sv
// Peripheral register bus bundle for periph_seg7_mux: address, strobes,
// acknowledge and a shared bidirectional data bus.
interface periph_seg7_mux_if #(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0] addr;
    wire  [DATA_WIDTH-1:0] data;
    logic                  read;
    logic                  write;
    logic                  ready;

    modport master (output addr, output read, output write, input ready, inout data);
    modport slave  (input addr, input read, input write, output ready, inout data);
endinterface

// File: rtl/periph_seg7_mux.sv
// Multiplexed 7-segment display controller with register-bus configuration.
// Scans DIGITS digits, one slot of PRESCALE clocks each, blanking the first
// BLANK clocks of every slot. Optional brightness PWM under macro SEG7_PWM_EN.
module periph_seg7_mux #(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned DIGITS         = 4,
    parameter int unsigned PRESCALE       = 1000,
    parameter int unsigned BLANK          = 16,
    parameter int unsigned SEG_ACTIVE_LOW = 1,
    parameter int unsigned DIG_ACTIVE_LOW = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    periph_seg7_mux_if.slave       bus,
    output logic [7:0]             seg,
    output logic [DIGITS-1:0]      dig
);
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned CNT_W = $clog2(PRESCALE);

    logic [CNT_W-1:0]  slot_cnt_q, slot_cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              tog_q, tog_d;
    logic [DIGITS-1:0] mask_q, mask_d;
    logic              raw_q, raw_d;
    logic              en_q, en_d;
    logic [7:0]        digr_q [DIGITS];
    logic [7:0]        digr_d [DIGITS];
    logic [7:0]        seg_q, seg_d;
    logic [DIGITS-1:0] dig_q, dig_d;
`ifdef SEG7_PWM_EN
    logic [3:0]        bright_q, bright_d;
    logic [3:0]        pwm_cnt_q, pwm_cnt_d;
`endif

    logic [DATA_WIDTH-1:0] rd_data_c;
    logic                  rd_en_c;
    logic                  data_unused;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h3F;
            4'h1: hex7 = 7'h06;
            4'h2: hex7 = 7'h5B;
            4'h3: hex7 = 7'h4F;
            4'h4: hex7 = 7'h66;
            4'h5: hex7 = 7'h6D;
            4'h6: hex7 = 7'h7D;
            4'h7: hex7 = 7'h07;
            4'h8: hex7 = 7'h7F;
            4'h9: hex7 = 7'h6F;
            4'hA: hex7 = 7'h77;
            4'hB: hex7 = 7'h7C;
            4'hC: hex7 = 7'h39;
            4'hD: hex7 = 7'h5E;
            4'hE: hex7 = 7'h79;
            4'hF: hex7 = 7'h71;
        endcase
    endfunction

    assign bus.ready   = bus.read | bus.write;
    assign rd_en_c     = bus.read & ~bus.write;
    assign bus.data    = rd_en_c ? rd_data_c : 'z;
    assign data_unused = ^bus.data;

    // Register read mux; unmapped addresses and unimplemented bits read 0
    always_comb begin
        rd_data_c = '0;
        case (bus.addr)
            ADDR_WIDTH'(0): rd_data_c = DATA_WIDTH'(32'h0000_7E60);
            ADDR_WIDTH'(1): rd_data_c = DATA_WIDTH'(32'h0001_0002);
            ADDR_WIDTH'(2): begin
                rd_data_c[DIGITS-1:0] = mask_q;
                rd_data_c[8]          = raw_q;
                rd_data_c[9]          = en_q;
`ifdef SEG7_PWM_EN
                rd_data_c[19:16]      = bright_q;
`endif
            end
            ADDR_WIDTH'(3): begin
                rd_data_c    = DATA_WIDTH'(idx_q);
                rd_data_c[8] = tog_q;
            end
            default: begin
                for (int i = 0; i < int'(DIGITS); i++) begin
                    if (bus.addr == ADDR_WIDTH'(4 + i)) rd_data_c = DATA_WIDTH'(digr_q[i]);
                end
            end
        endcase
    end

    // Register writes: only implemented bits are kept, RO/unmapped ignored
    always_comb begin
        mask_d = mask_q;
        raw_d  = raw_q;
        en_d   = en_q;
        digr_d = digr_q;
`ifdef SEG7_PWM_EN
        bright_d = bright_q;
`endif
        if (bus.write) begin
            if (bus.addr == ADDR_WIDTH'(2)) begin
                mask_d = bus.data[DIGITS-1:0];
                raw_d  = bus.data[8];
                en_d   = bus.data[9];
`ifdef SEG7_PWM_EN
                bright_d = bus.data[19:16];
`endif
            end
            for (int i = 0; i < int'(DIGITS); i++) begin
                if (bus.addr == ADDR_WIDTH'(4 + i)) digr_d[i] = bus.data[7:0];
            end
        end
    end

    // Scan timing: slot counter, digit index and frame toggle
    always_comb begin
        slot_cnt_d = slot_cnt_q + 1'b1;
        idx_d      = idx_q;
        tog_d      = tog_q;
        if (slot_cnt_q == CNT_W'(PRESCALE - 1)) begin
            slot_cnt_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) begin
                idx_d = '0;
                tog_d = ~tog_q;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
    end

    // Next output pattern for the digit currently being scanned
    always_comb begin
        logic [7:0]        cur;
        logic [7:0]        pat;
        logic              on;
        logic [7:0]        seg_log;
        logic [DIGITS-1:0] dig_log;
        cur = digr_q[idx_q];
        pat = raw_q ? cur : {cur[4], hex7(cur[3:0])};
        on  = en_q & mask_q[idx_q] & (slot_cnt_q >= CNT_W'(BLANK)) & (raw_q | ~cur[5]);
`ifdef SEG7_PWM_EN
        pwm_cnt_d = pwm_cnt_q + 1'b1;
        on        = on & (pwm_cnt_q <= bright_q);
`endif
        seg_log = on ? pat : 8'h00;
        dig_log = on ? (DIGITS'(1) << idx_q) : '0;
        seg_d   = (SEG_ACTIVE_LOW != 0) ? ~seg_log : seg_log;
        dig_d   = (DIG_ACTIVE_LOW != 0) ? ~dig_log : dig_log;
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q <= '0;
            idx_q      <= '0;
            tog_q      <= 1'b0;
            mask_q     <= '0;
            raw_q      <= 1'b0;
            en_q       <= 1'b0;
            for (int i = 0; i < int'(DIGITS); i++) digr_q[i] <= '0;
            seg_q      <= (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
            dig_q      <= (DIG_ACTIVE_LOW != 0) ? '1 : '0;
`ifdef SEG7_PWM_EN
            bright_q   <= '0;
            pwm_cnt_q  <= '0;
`endif
        end else begin
            slot_cnt_q <= slot_cnt_d;
            idx_q      <= idx_d;
            tog_q      <= tog_d;
            mask_q     <= mask_d;
            raw_q      <= raw_d;
            en_q       <= en_d;
            digr_q     <= digr_d;
            seg_q      <= seg_d;
            dig_q      <= dig_d;
`ifdef SEG7_PWM_EN
            bright_q   <= bright_d;
            pwm_cnt_q  <= pwm_cnt_d;
`endif
        end
    end

    assign seg = seg_q;
    assign dig = dig_q;
endmodule

// File: tb/tb_periph_seg7_mux.sv
// Bench for periph_seg7_mux (DIGITS=4, PRESCALE=8, BLANK=2, active-low).
// Honours SEG7_PWM_EN when defined for the build.
module tb_periph_seg7_mux;
    localparam int DW = 32;
    localparam int AW = 4;
    localparam int ND = 4;
    localparam int PS = 8;
    localparam int BL = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst;
    logic [7:0]     seg;
    logic [ND-1:0]  dig;
    logic           tb_den;
    logic [DW-1:0]  tb_dout;
    logic           chk_on;

    periph_seg7_mux_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();
    assign bus.data = tb_den ? tb_dout : 'z;

    periph_seg7_mux #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DIGITS(ND), .PRESCALE(PS), .BLANK(BL),
        .SEG_ACTIVE_LOW(1), .DIG_ACTIVE_LOW(1)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus), .seg(seg), .dig(dig)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: scan position derived from clocks since reset
    int          cyc;
    bit          mvalid = 0;
    logic [3:0]  m_mask;
    bit          m_raw, m_en;
    logic [3:0]  m_bright;
    logic [7:0]  m_dig [ND];
    logic [7:0]  exp_seg;
    logic [3:0]  exp_dig;
    logic [6:0]  hex_tbl [16];

    function automatic void model_drive();
        int         slot;
        int         idx;
        logic [7:0] d;
        logic [7:0] pat;
        bit         on;
        slot = cyc % PS;
        idx  = (cyc / PS) % ND;
        d    = m_dig[idx];
        on   = m_en && m_mask[idx] && (slot >= BL) && (m_raw || !d[5]);
`ifdef SEG7_PWM_EN
        on   = on && ((cyc % 16) <= int'(m_bright));
`endif
        pat     = m_raw ? d : {d[4], hex_tbl[d[3:0]]};
        exp_seg = on ? ~pat : 8'hFF;
        exp_dig = on ? ~(4'b0001 << idx) : 4'hF;
    endfunction

    function automatic void model_write(input logic [3:0] a, input logic [31:0] v);
        if (a == 4'd2) begin
            m_mask = v[3:0];
            m_raw  = v[8];
            m_en   = v[9];
`ifdef SEG7_PWM_EN
            m_bright = v[19:16];
`endif
        end else if (a >= 4'd4 && a <= 4'd7) begin
            m_dig[a - 4'd4] = v[7:0];
        end
    endfunction

    function automatic logic [31:0] model_reg(input logic [3:0] a);
        logic [31:0] r;
        r = 32'h0;
        case (a)
            4'd0: r = 32'h0000_7E60;
            4'd1: r = 32'h0001_0002;
            4'd2: r = {12'h0, m_bright, 6'h0, m_en, m_raw, 4'h0, m_mask};
            4'd3: r = 32'((cyc / PS) % ND) | (32'((cyc / (PS * ND)) % 2) << 8);
            4'd4, 4'd5, 4'd6, 4'd7: r = {24'h0, m_dig[a - 4'd4]};
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            cyc = 0; mvalid = 1;
            m_mask = 0; m_raw = 0; m_en = 0; m_bright = 0;
            for (int i = 0; i < ND; i++) m_dig[i] = 8'h00;
            exp_seg = 8'hFF; exp_dig = 4'hF;
        end else if (mvalid) begin
            model_drive();
            if (bus.write) model_write(bus.addr, tb_dout);
            cyc++;
        end
    end

    always @(negedge clk) begin
        if (chk_on && mvalid) begin
            check("seg", 32'(seg), 32'(exp_seg));
            check("dig", 32'(dig), 32'(exp_dig));
        end
    end

    task automatic do_write(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        bus.addr = a; bus.write = 1'b1; tb_dout = v; tb_den = 1'b1;
        @(negedge clk);
        bus.write = 1'b0; tb_den = 1'b0;
    endtask

    task automatic do_read_exp(input logic [3:0] a, input logic [31:0] exp, input string name);
        @(negedge clk);
        bus.addr = a; bus.read = 1'b1;
        #1;
        check(name, bus.data, exp);
        check({name, "_ready"}, 32'(bus.ready), 32'd1);
        bus.read = 1'b0;
    endtask

    task automatic do_read_model(input logic [3:0] a, output logic [31:0] got);
        @(negedge clk);
        bus.addr = a; bus.read = 1'b1;
        #1;
        got = bus.data;
        check($sformatf("rd_addr%0d", a), got, model_reg(a));
        bus.read = 1'b0;
    endtask

    task automatic count_window(input int n, input logic [3:0] dpat, input logic [7:0] spat,
                                output int cd, output int cm);
        cd = 0; cm = 0;
        repeat (n) begin
            @(negedge clk);
            if (dig == dpat) begin
                cd++;
                if (seg == spat) cm++;
            end
        end
    endtask

    task automatic count_active(input int n, output int ca);
        ca = 0;
        repeat (n) begin
            @(negedge clk);
            if (dig != 4'hF) ca++;
        end
    endtask

    typedef struct {
        logic [3:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t        vecs [8];
        int          cd, cm, ca;
        logic [31:0] s1, s2, got;
        bit          seen;

        hex_tbl = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
`ifdef SEG7_PWM_EN
        vecs[0] = '{4'd2,  32'hFFFF_FFFF, 32'h000F_030F};
`else
        vecs[0] = '{4'd2,  32'hFFFF_FFFF, 32'h0000_030F};
`endif
        vecs[1] = '{4'd4,  32'hFFFF_FF3C, 32'h0000_003C};
        vecs[2] = '{4'd0,  32'h1234_5678, 32'h0000_7E60};
        vecs[3] = '{4'd1,  32'h0000_0000, 32'h0001_0002};
        vecs[4] = '{4'd15, 32'hFFFF_FFFF, 32'h0000_0000};
        vecs[5] = '{4'd8,  32'h0000_FFFF, 32'h0000_0000};
        vecs[6] = '{4'd7,  32'h0000_0181, 32'h0000_0081};
        vecs[7] = '{4'd2,  32'h0000_0000, 32'h0000_0000};

        rst = 1'b1; bus.addr = '0; bus.read = 1'b0; bus.write = 1'b0;
        tb_den = 1'b0; tb_dout = '0; chk_on = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; chk_on = 1'b1;

        // Reset state and idle outputs
        do_read_exp(4'd3, 32'h0, "status_after_reset");
        count_window(40, 4'hF, 8'hFF, cd, cm);
        check("idle_dig_off", 32'(cd), 32'd40);
        check("idle_seg_off", 32'(cm), 32'd40);

        // Register write/readback table
        for (int i = 0; i < 8; i++) begin
            do_write(vecs[i].addr, vecs[i].wdata);
            do_read_exp(vecs[i].addr, vecs[i].exp, $sformatf("vec%0d", i));
        end

        // Hex scan with blank interval and DP
        do_write(4'd4, 32'h03);
        do_write(4'd5, 32'h1A);
        do_write(4'd6, 32'h00);
        do_write(4'd7, 32'h00);
        do_write(4'd2, 32'h20F);
        count_window(32, 4'b1110, 8'hB0, cd, cm);
        check("slot0_cnt", 32'(cd), 32'd6);
        check("slot0_seg", 32'(cm), 32'd6);
        count_window(32, 4'b1101, 8'h08, cd, cm);
        check("slot1_cnt", 32'(cd), 32'd6);
        check("slot1_seg", 32'(cm), 32'd6);
        count_window(32, 4'b0111, 8'hC0, cd, cm);
        check("slot3_zero", 32'(cm), 32'd6);

        // Per-digit blank, then mask-off of digit 2
        do_write(4'd6, 32'h20);
        count_window(32, 4'b1011, 8'hFF, cd, cm);
        check("blank_dig2", 32'(cd), 32'd0);
        count_window(32, 4'b1110, 8'hB0, cd, cm);
        check("blank_other", 32'(cm), 32'd6);
        do_write(4'd6, 32'h00);
        do_write(4'd2, 32'h20B);
        count_window(32, 4'b1011, 8'hFF, cd, cm);
        check("mask_dig2", 32'(cd), 32'd0);

        // Frame toggle period
        do_read_model(4'd3, s1);
        repeat (31) @(negedge clk);
        do_read_model(4'd3, s2);
        check("tog_flip", 32'(s1[8] ^ s2[8]), 32'd1);

        // RAW mode
        do_write(4'd2, 32'h30F);
        do_write(4'd7, 32'h81);
        count_window(32, 4'b0111, 8'h7E, cd, cm);
        check("raw_slot3", 32'(cm), 32'd6);

        // Read and write together: DUT must not drive, write must land
        @(negedge clk);
        bus.addr = 4'd5; bus.read = 1'b1; bus.write = 1'b1; tb_dout = 32'h55; tb_den = 1'b1;
        #1;
        check("rw_data_not_driven", bus.data, 32'h55);
        @(negedge clk);
        bus.read = 1'b0; bus.write = 1'b0; tb_den = 1'b0;
        do_read_exp(4'd5, 32'h55, "rw_landed");

        // Brightness
        do_write(4'd5, 32'h1A);
        do_write(4'd2, 32'h3020F);
        count_active(128, ca);
`ifdef SEG7_PWM_EN
        check("pwm_b3", 32'(ca), 32'd16);
`else
        check("nopwm_b3", 32'(ca), 32'd96);
`endif
        do_write(4'd2, 32'hF020F);
        count_active(128, ca);
        check("pwm_b15", 32'(ca), 32'd96);

        // Reset mid-slot with a concurrent write
        seen = 0;
        for (int k = 0; k < 64 && !seen; k++) begin
            @(negedge clk);
            if (dig != 4'hF) seen = 1;
        end
        check("active_before_rst", 32'(seen), 32'd1);
        rst = 1'b1; bus.addr = 4'd4; bus.write = 1'b1; tb_dout = 32'h77; tb_den = 1'b1;
        @(negedge clk);
        check("rst_seg", 32'(seg), 32'hFF);
        check("rst_dig", 32'(dig), 32'hF);
        rst = 1'b0; bus.write = 1'b0; tb_den = 1'b0;
        do_read_exp(4'd3, 32'h0, "rst_status");
        do_read_exp(4'd4, 32'h0, "rst_dig0");
        do_read_exp(4'd2, 32'h0, "rst_cfg");

        // Randomised traffic against the model
        for (int n = 0; n < 300; n++) begin
            int          op;
            logic [3:0]  a;
            logic [31:0] v;
            op = int'($urandom_range(0, 9));
            a  = 4'($urandom_range(0, 15));
            v  = $urandom;
            if (op < 4) begin
                if ($urandom_range(0, 2) != 0) a = 4'($urandom_range(2, 7));
                if (a == 4'd2 && $urandom_range(0, 3) != 0) v[9] = 1'b1;
                do_write(a, v);
            end else if (op < 7) begin
                do_read_model(a, got);
            end else if (op < 9) begin
                repeat ($urandom_range(1, 20)) @(negedge clk);
            end else if ($urandom_range(0, 4) == 0) begin
                @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
            end
        end

        chk_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
